serial_adder_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit full-adder cell: latches two WIDTH-bit operands,

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_ctrl_if.sv | 35 +++
 rtl/full_adder_cell.sv | 11 +
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit counter runs 0..WIDTH-1, so $clog2(WIDTH) bits suffice for WIDTH >= 2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf_out.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start_in;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             C_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] Sum_out;
  logic             C_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_out;

  modport master (
    output start_in, A_in, B_in, C_in,
    input  busy_out, done_out, Sum_out, C_out, ovf_out
  );
  modport slave (
    input  start_in, A_in, B_in, C_in,
    output busy_out, done_out, Sum_out, C_out, ovf_out
  );
`else
  modport master (
    output start_in, A_in, B_in, C_in,
    input  busy_out, done_out, Sum_out, C_out
  );
  modport slave (
    input  start_in, A_in, B_in, C_in,
    output busy_out, done_out, Sum_out, C_out
  );
`endif
endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic in the serial adder datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: pushes one bit pair per clock through a single full-adder cell.
// SERIAL_ADDER_OVF_EN enables the registered signed-overflow output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                clk_in,
  input logic                rst_in,
  serial_adder_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic cell_s;
  logic cell_co;

  full_adder_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_co)
  );

  // NOTE: every register here updates with <= so all reads in this block see pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            state_q <= RUN;
            cnt_q   <= '0;
            a_sh_q  <= bus.A_in;
            b_sh_q  <= bus.B_in;
            carry_q <= bus.C_in;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q   <= {cell_s, sum_q[WIDTH-1:1]};
          carry_q <= cell_co;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            cout_q  <= cell_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q holds the carry into the MSB on this last edge
            ovf_q   <= carry_q ^ cell_co;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
  assign bus.Sum_out  = sum_q;
  assign bus.C_out    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    return s[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > 127) || (s < -128);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, bus.busy_out, 0);
    check({tag, "_done"}, bus.done_out, 0);
    check({tag, "_sum"}, {bus.C_out, bus.Sum_out}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, bus.ovf_out, 0);
`endif
  endtask

  // One operation; inject_at (1..9) pulses a spurious start in that cycle, 0 = none.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int inject_at, input string tag);
    logic [8:0] exp;
    logic       exp_ovf;
    int         done_cnt;
    int         done_k;
    exp      = ref_sum(a, b, cin);
    exp_ovf  = ref_ovf(a, b, cin);
    done_cnt = 0;
    done_k   = -1;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.A_in     = a;
    bus.B_in     = b;
    bus.C_in     = cin;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start_in = (k == inject_at);
      bus.A_in     = 8'($urandom);
      bus.B_in     = 8'($urandom);
      bus.C_in     = 1'($urandom);
      check({tag, "_busy"}, bus.busy_out, (k <= 9));
      if (k == 1) begin
        check({tag, "_clr"}, {bus.C_out, bus.Sum_out}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovfclr"}, bus.ovf_out, 0);
`endif
      end
      if (bus.done_out) begin
        done_cnt++;
        done_k = k;
        check({tag, "_sum"}, {bus.C_out, bus.Sum_out}, exp);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, bus.ovf_out, exp_ovf);
`endif
      end
    end
    check({tag, "_pulses"}, done_cnt, 1);
    check({tag, "_latency"}, done_k, 9);
    check({tag, "_hold"}, {bus.C_out, bus.Sum_out}, exp);
  endtask

  task automatic reset_mid_run(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.A_in     = a;
    bus.B_in     = b;
    bus.C_in     = cin;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done_out) done_cnt++;
      if (k == 11) check("midrst_busy_after", bus.busy_out, 0);
    end
    check("midrst_no_done", done_cnt, 0);
  endtask

  task automatic start_held();
    logic [8:0] hold_exp [30];
    logic       hold_ovf [30];
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         m;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (n > 0) begin
        m = n - 1;
        check("held_busy", bus.busy_out, (m % 10) != 9);
        check("held_done", bus.done_out, (m % 10) == 8);
        if ((m % 10) == 8) begin
          check("held_sum", {bus.C_out, bus.Sum_out}, hold_exp[m-8]);
`ifdef SERIAL_ADDER_OVF_EN
          check("held_ovf", bus.ovf_out, hold_ovf[m-8]);
`endif
        end
      end
      if (n < 30) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        bus.start_in = 1'b1;
        bus.A_in     = a;
        bus.B_in     = b;
        bus.C_in     = cin;
        hold_exp[n]  = ref_sum(a, b, cin);
        hold_ovf[n]  = ref_ovf(a, b, cin);
      end else begin
        bus.start_in = 1'b0;
      end
    end
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.A_in     = '0;
    bus.B_in     = '0;
    bus.C_in     = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_op(8'h5A, 8'h3C, 1'b0, 0, "dir_5a3c");
    run_op(8'hFF, 8'h01, 1'b0, 0, "dir_ff01");
    run_op(8'hFF, 8'hFF, 1'b1, 0, "dir_ffff1");
    run_op(8'h7F, 8'h01, 1'b0, 0, "dir_7f01");
    run_op(8'h80, 8'h80, 1'b0, 0, "dir_8080");
    run_op(8'h10, 8'h20, 1'b0, 0, "dir_1020");
    run_op(8'h5A, 8'h3C, 1'b0, 3, "inject_run");
    run_op(8'hA5, 8'hC3, 1'b1, 9, "inject_done");

    reset_mid_run(8'hFF, 8'hFF, 1'b1);
    run_op(8'h12, 8'h34, 1'b1, 0, "after_rst");

    start_held();
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 9)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
